// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the memory-access stage.
// Holds funct3 load/store size codes, writeback-select encodings, FSM states
// and the EX/MEM bundle that is captured while an access is outstanding.
package mem_pkg;
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        regwrite;
    logic        rd_mem;
    logic        wr_mem;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] rs2;
  } exmem_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane logic for the memory stage.
// Ports: i_op (funct3), i_addr (byte offset), i_rs2 (store data), i_rdata (read word)
//        -> o_be (byte enables), o_wdata (lane-replicated store data),
//           o_load (aligned, extended load data), o_misalign.
// Macro MEM_MISALIGN_CHK_EN: when defined, misaligned H/W are flagged;
// otherwise the low offset bits are masked and misalign is tied low.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load,
  output logic        o_misalign
);
  logic        w_b, w_h, w_w, w_uns;
  logic [1:0]  w_a;
  logic [31:0] w_sh;
  assign w_b   = i_op == MEM_B || i_op == MEM_BU;
  assign w_h   = i_op == MEM_H || i_op == MEM_HU;
  assign w_w   = i_op == MEM_W;
  assign w_uns = i_op == MEM_BU || i_op == MEM_HU;
`ifdef MEM_MISALIGN_CHK_EN
  assign w_a        = i_addr;
  assign o_misalign = (w_h && i_addr[0]) || (w_w && i_addr != 2'b00);
`else
  assign w_a        = w_w ? 2'b00 : w_h ? {i_addr[1], 1'b0} : i_addr;
  assign o_misalign = 1'b0;
`endif
  assign o_be    = w_b ? 4'b0001 << w_a : w_h ? 4'b0011 << w_a : 4'b1111;
  assign o_wdata = w_b ? {4{i_rs2[7:0]}} : w_h ? {2{i_rs2[15:0]}} : i_rs2;
  assign w_sh    = i_rdata >> {w_a, 3'b000};
  assign o_load  = w_b ? {{24{!w_uns && w_sh[7]}}, w_sh[7:0]} :
                   w_h ? {{16{!w_uns && w_sh[15]}}, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with ready/valid data-memory port.
// Inputs: EX/MEM register fields (MEM_*), dmem_ready_i/dmem_rdata_i.
// Outputs: dmem request (req/we/addr/be/wdata), stall_o, MEM_fwd_data_o,
//          MEM/WB register (WB_*), misalign_o pulse.
// Macro MEM_MISALIGN_CHK_EN enables misalignment detection (see mem_align).
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           MEM_pc_i,
  input  logic [4:0]            MEM_rd_add_i,
  input  logic [1:0]            MEM_sel_to_reg_i,
  input  logic                  MEM_regwrite_i,
  input  logic                  MEM_RD_mem_i,
  input  logic                  MEM_WR_mem_i,
  input  logic [3:0]            MEM_mem_op_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ready_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] MEM_fwd_data_o,
  output logic [4:0]            WB_rd_add_o,
  output logic                  WB_regwrite_o,
  output logic [1:0]            WB_sel_to_reg_o,
  output logic [DATA_WIDTH-1:0] WB_alu_result_o,
  output logic [DATA_WIDTH-1:0] WB_load_data_o,
  output logic [31:0]           WB_pc4_o,
  output logic                  misalign_o
);
  state_t      r_state;
  exmem_t      r_hold, w_in, w_src;
  logic        w_op, w_mis, w_req;
  logic [31:0] w_load;
  logic        w_unused;
  assign w_unused = ^{MEM_mem_op_i[3], SEL_ALU, SEL_LOAD, SEL_PC4};
  assign w_in = '{pc: MEM_pc_i, rd: MEM_rd_add_i, sel: MEM_sel_to_reg_i,
                  regwrite: MEM_regwrite_i, rd_mem: MEM_RD_mem_i, wr_mem: MEM_WR_mem_i,
                  op: MEM_mem_op_i[2:0], alu: MEM_alu_result_i, rs2: MEM_rs2_data_i};
  // The whole instruction is held in WAIT so the request and the eventual
  // writeback are independent of whatever sits on the inputs meanwhile.
  assign w_src = r_state == ST_WAIT ? r_hold : w_in;
  mem_align u_align (
    .i_op      (w_src.op),
    .i_addr    (w_src.alu[1:0]),
    .i_rs2     (w_src.rs2),
    .i_rdata   (dmem_rdata_i),
    .o_be      (dmem_be_o),
    .o_wdata   (dmem_wdata_o),
    .o_load    (w_load),
    .o_misalign(w_mis)
  );
  assign w_op           = w_src.rd_mem || w_src.wr_mem;
  assign w_req          = !rst && w_op && !w_mis;
  assign dmem_req_o     = w_req;
  assign dmem_we_o      = w_req && w_src.wr_mem && !w_src.rd_mem;
  assign stall_o        = w_req && !dmem_ready_i;
  assign dmem_addr_o    = {w_src.alu[ADDR_WIDTH-1:2], 2'b00};
  assign MEM_fwd_data_o = MEM_alu_result_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_hold          <= '0;
      WB_rd_add_o     <= '0;
      WB_regwrite_o   <= 1'b0;
      WB_sel_to_reg_o <= '0;
      WB_alu_result_o <= '0;
      WB_load_data_o  <= '0;
      WB_pc4_o        <= '0;
      misalign_o      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_hold <= w_in;
      r_state    <= stall_o ? ST_WAIT : ST_IDLE;
      misalign_o <= w_op && w_mis;
      if (stall_o) begin
        WB_rd_add_o   <= '0;
        WB_regwrite_o <= 1'b0;
      end else begin
        WB_rd_add_o     <= w_src.rd;
        WB_regwrite_o   <= w_src.regwrite && !(w_op && w_mis);
        WB_sel_to_reg_o <= w_src.sel;
        WB_alu_result_o <= w_src.alu;
        WB_load_data_o  <= w_load;
        WB_pc4_o        <= w_src.pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (directed plan plus random aligned accesses).
module tb_mem_stage;
  import mem_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] MEM_pc_i = '0, MEM_alu_result_i = '0, MEM_rs2_data_i = '0;
  logic [4:0]  MEM_rd_add_i = '0;
  logic [1:0]  MEM_sel_to_reg_i = '0;
  logic        MEM_regwrite_i = 0, MEM_RD_mem_i = 0, MEM_WR_mem_i = 0;
  logic [3:0]  MEM_mem_op_i = '0;
  logic        dmem_req_o, dmem_we_o, dmem_ready_i = 0, stall_o, WB_regwrite_o, misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0, MEM_fwd_data_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  WB_rd_add_o;
  logic [1:0]  WB_sel_to_reg_o;
  logic [31:0] WB_alu_result_o, WB_load_data_o, WB_pc4_o;

  mem_stage dut (
    .clk(clk), .rst(rst), .MEM_pc_i(MEM_pc_i), .MEM_rd_add_i(MEM_rd_add_i),
    .MEM_sel_to_reg_i(MEM_sel_to_reg_i), .MEM_regwrite_i(MEM_regwrite_i),
    .MEM_RD_mem_i(MEM_RD_mem_i), .MEM_WR_mem_i(MEM_WR_mem_i), .MEM_mem_op_i(MEM_mem_op_i),
    .MEM_alu_result_i(MEM_alu_result_i), .MEM_rs2_data_i(MEM_rs2_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .MEM_fwd_data_o(MEM_fwd_data_o),
    .WB_rd_add_o(WB_rd_add_o), .WB_regwrite_o(WB_regwrite_o), .WB_sel_to_reg_o(WB_sel_to_reg_o),
    .WB_alu_result_o(WB_alu_result_o), .WB_load_data_o(WB_load_data_o), .WB_pc4_o(WB_pc4_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu, ld, pc4;
    logic        mis, is_ld;
  } exp_t;
  exp_t        q[$];
  int          n_vec = 0, n_err = 0;
  logic [31:0] pc = 32'h1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input int n, input int a);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (i >= a) && (i < a + n);
    return r;
  endfunction

  function automatic logic [31:0] ref_wd(input int n, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_ld(input int n, input int a, input logic uns, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = (i < n) ? d[8*(a+i) +: 8] : (uns ? 8'h00 : {8{d[8*(a+n)-1]}});
    return r;
  endfunction

  // Drives one EX/MEM instruction, holds ready low for `waits` cycles, then checks
  // the request on the completing cycle and the MEM/WB register one edge later.
  task automatic run_op(input logic rd_m, input logic wr_m, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                        input logic [4:0] rd, input logic rw, input logic [1:0] sel, input int waits,
                        input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_ld, input logic exp_mis);
    exp_t e;
    logic exp_we;
    exp_we = wr_m && !rd_m;
    MEM_pc_i = pc; MEM_rd_add_i = rd; MEM_sel_to_reg_i = sel; MEM_regwrite_i = rw;
    MEM_RD_mem_i = rd_m; MEM_WR_mem_i = wr_m; MEM_mem_op_i = {1'b0, op};
    MEM_alu_result_i = addr; MEM_rs2_data_i = rs2;
    dmem_ready_i = (waits == 0);
    dmem_rdata_i = (waits == 0) ? rdata : 32'hDEAD_BEEF;
    q.push_back('{rd, rw && !exp_mis, sel, addr, exp_ld, pc + 32'd4, exp_mis, rd_m});
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      check("stall_hi", stall_o, 1'b1);
      check("req_wait", dmem_req_o, 1'b1);
      check("addr_wait", dmem_addr_o, {addr[31:2], 2'b00});
      @(posedge clk); #1;
      check("bubble_rw", WB_regwrite_o, 1'b0);
      check("bubble_rd", WB_rd_add_o, 5'd0);
      if (w == waits - 1) begin
        dmem_ready_i = 1'b1;
        dmem_rdata_i = rdata;
      end
    end
    @(negedge clk);
    check("stall_lo", stall_o, 1'b0);
    check("req", dmem_req_o, exp_req);
    if (exp_req) begin
      check("we", dmem_we_o, exp_we);
      check("addr", dmem_addr_o, {addr[31:2], 2'b00});
      check("be", dmem_be_o, exp_be);
      if (exp_we) check("wdata", dmem_wdata_o, exp_wd);
    end
    @(posedge clk); #1;
    e = q.pop_front();
    check("wb_rw", WB_regwrite_o, e.rw);
    if (e.rw) check("wb_rd", WB_rd_add_o, e.rd);
    check("wb_sel", WB_sel_to_reg_o, e.sel);
    check("wb_alu", WB_alu_result_o, e.alu);
    check("wb_pc4", WB_pc4_o, e.pc4);
    check("misalign", misalign_o, e.mis);
    if (e.is_ld && !e.mis) check("wb_load", WB_load_data_o, e.ld);
    pc = pc + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    MEM_RD_mem_i = 1'b1; MEM_mem_op_i = {1'b0, MEM_W}; MEM_regwrite_i = 1'b1;
    #3;
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_we", dmem_we_o, 1'b0);
    check("rst_wb_rw", WB_regwrite_o, 1'b0);
    check("rst_wb_pc4", WB_pc4_o, 32'd0);
    check("rst_mis", misalign_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("fwd", MEM_fwd_data_o, 32'd0);

    run_op(0, 0, MEM_B, 32'h0000_1234, 0, 0, 5'd5, 1, SEL_ALU, 0, 0, 4'h0, 0, 0, 0);
    run_op(0, 1, MEM_B, 32'h103, 32'hA5, 0, 5'd0, 0, SEL_ALU, 0, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0);
    run_op(1, 0, MEM_B, 32'h102, 0, 32'h0080_0000, 5'd7, 1, SEL_LOAD, 3, 1, 4'b0100, 0, 32'hFFFF_FF80, 0);
    run_op(1, 0, MEM_HU, 32'h202, 0, 32'h8001_0000, 5'd9, 1, SEL_LOAD, 0, 1, 4'b1100, 0, 32'h0000_8001, 0);
`ifdef MEM_MISALIGN_CHK_EN
    run_op(1, 0, MEM_W, 32'h301, 0, 32'h1234_5678, 5'd10, 1, SEL_LOAD, 0, 0, 4'b1111, 0, 32'h1234_5678, 1);
`else
    run_op(1, 0, MEM_W, 32'h301, 0, 32'h1234_5678, 5'd10, 1, SEL_LOAD, 0, 1, 4'b1111, 0, 32'h1234_5678, 0);
`endif
    run_op(0, 1, MEM_H, 32'h402, 32'h1234_BEEF, 0, 5'd0, 0, SEL_ALU, 1, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0);
    run_op(1, 1, MEM_W, 32'h500, 32'h1111_1111, 32'hCAFE_F00D, 5'd11, 1, SEL_LOAD, 0, 1, 4'b1111, 0, 32'hCAFE_F00D, 0);
    run_op(0, 0, MEM_B, 32'h0000_0042, 0, 0, 5'd1, 1, SEL_PC4, 0, 0, 4'h0, 0, 0, 0);

    for (int k = 0; k < 10; k++) begin
      logic [2:0]  op;
      logic        st;
      int          n, a, w;
      logic [31:0] addr, rs2, rd_word;
      st = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: op = MEM_B;
        1: op = MEM_H;
        2: op = MEM_W;
        3: op = st ? MEM_B : MEM_BU;
        default: op = st ? MEM_H : MEM_HU;
      endcase
      n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
      a = (n == 1) ? int'($urandom_range(0, 3)) : (n == 2) ? 2 * int'($urandom_range(0, 1)) : 0;
      addr = ($urandom & 32'hFFFF_FFFC) | 32'(a);
      rs2 = $urandom; rd_word = $urandom;
      w = $urandom_range(0, 2);
      run_op(!st, st, op, addr, rs2, rd_word, 5'(k + 12), !st, st ? SEL_ALU : SEL_LOAD, w,
             1, ref_be(n, a), ref_wd(n, rs2), ref_ld(n, a, op[2], rd_word), 0);
    end

    MEM_pc_i = 32'h2000; MEM_RD_mem_i = 1'b1; MEM_WR_mem_i = 1'b0; MEM_mem_op_i = {1'b0, MEM_B};
    MEM_alu_result_i = 32'h600; MEM_rd_add_i = 5'd3; MEM_regwrite_i = 1'b1; dmem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_stall", stall_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_req", dmem_req_o, 1'b0);
    check("arst_stall", stall_o, 1'b0);
    check("arst_wb_alu", WB_alu_result_o, 32'd0);
    check("arst_wb_pc4", WB_pc4_o, 32'd0);
    check("arst_wb_sel", WB_sel_to_reg_o, 2'd0);
    check("arst_wb_ld", WB_load_data_o, 32'd0);
    @(posedge clk); #1;
    MEM_RD_mem_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    run_op(1, 0, MEM_H, 32'h702, 0, 32'h8421_0000, 5'd4, 1, SEL_LOAD, 0, 1, 4'b1100, 0, 32'hFFFF_8421, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
